cla_addsub_pipe: RTL and testbench

//  Parametrised, pipelined carry-lookahead adder/subtractor; successor to the fixed 8-bit CLA.

---
 rtl/cla_pkg.sv | 22 ++
 rtl/cla_slice.sv | 109 ++++++++++
 rtl/cla_addsub_pipe.sv | 150 +++++++++++++++
 tb/tb_cla_addsub_pipe.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// ---------------------------------------------------------------------------
// cla_pkg
//   Shared definitions for the pipelined carry-lookahead adder/subtractor.
//   GRP_W     : width of a first-level lookahead group inside a slice.
//   op_e      : operation select (add / subtract).
//   carry_in0 : carry injected into the lowest slice for a given operation.
// ---------------------------------------------------------------------------
package cla_pkg;

    localparam int GRP_W = 4;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // Subtraction is A + ~B + 1, so the external carry is replaced by 1.
    function automatic logic carry_in0(input op_e op, input logic cin);
        return (op == OP_SUB) ? 1'b1 : cin;
    endfunction

endpackage

// File: rtl/cla_slice.sv
// ---------------------------------------------------------------------------
// cla_slice
//   Combinational SW-bit two-level carry-lookahead adder.
//   First level: 4-bit groups with per-bit lookahead carries and group
//   generate/propagate. Second level: lookahead over the group G/P terms to
//   produce every group carry directly from cin.
// Ports
//   a, b   in  SW  operands (b already inverted by the caller for subtract)
//   cin    in  1   carry into bit 0
//   sum    out SW  a + b + cin (mod 2^SW)
//   cout   out 1   carry out of bit SW-1
//   c_msb  out 1   carry into bit SW-1 (for signed overflow)
//   zero   out 1   sum == 0
// ---------------------------------------------------------------------------
module cla_slice
    import cla_pkg::*;
#(
    parameter int SW = 8
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          cin,
    output logic [SW-1:0] sum,
    output logic          cout,
    output logic          c_msb,
    output logic          zero
);

    localparam int NG = SW / GRP_W;

    logic [SW-1:0] g;
    logic [SW-1:0] p;
    logic [SW-1:0] c;     // c[i] = carry into bit i
    logic [NG-1:0] gg;    // group generate
    logic [NG-1:0] pp;    // group propagate
    logic [NG:0]   cg;    // cg[k] = carry into group k, cg[NG] = carry out
    logic          tg;
    logic          tc;
    logic          tb;

    assign g = a & b;
    assign p = a ^ b;

    // Group G/P in sum-of-products form: G = g3 | p3g2 | p3p2g1 | p3p2p1g0.
    always_comb begin
        gg = '0;
        pp = '0;
        tg = 1'b0;
        for (int k = 0; k < NG; k++) begin
            pp[k] = &p[k*GRP_W +: GRP_W];
            for (int j = 0; j < GRP_W; j++) begin
                tg = g[k*GRP_W + j];
                for (int m = j + 1; m < GRP_W; m++) begin
                    tg = tg & p[k*GRP_W + m];
                end
                gg[k] = gg[k] | tg;
            end
        end
    end

    // Second level: each group carry is a flat OR of products of group terms
    // and cin, so no carry ripples from group to group.
    always_comb begin
        cg = '0;
        tc = 1'b0;
        for (int k = 0; k <= NG; k++) begin
            tc = cin;
            for (int m = 0; m < k; m++) begin
                tc = tc & pp[m];
            end
            cg[k] = tc;
            for (int j = 0; j < k; j++) begin
                tc = gg[j];
                for (int m = j + 1; m < k; m++) begin
                    tc = tc & pp[m];
                end
                cg[k] = cg[k] | tc;
            end
        end
    end

    // Per-bit carries inside each group, looked ahead from the group carry.
    always_comb begin
        c  = '0;
        tb = 1'b0;
        for (int k = 0; k < NG; k++) begin
            for (int i = 0; i < GRP_W; i++) begin
                tb = cg[k];
                for (int m = 0; m < i; m++) begin
                    tb = tb & p[k*GRP_W + m];
                end
                c[k*GRP_W + i] = tb;
                for (int j = 0; j < i; j++) begin
                    tb = g[k*GRP_W + j];
                    for (int m = j + 1; m < i; m++) begin
                        tb = tb & p[k*GRP_W + m];
                    end
                    c[k*GRP_W + i] = c[k*GRP_W + i] | tb;
                end
            end
        end
    end

    assign sum   = p ^ c;
    assign cout  = cg[NG];
    assign c_msb = c[SW-1];
    assign zero  = ~|sum;

endmodule

// File: rtl/cla_addsub_pipe.sv
// ---------------------------------------------------------------------------
// cla_addsub_pipe
//   Pipelined WIDTH-bit carry-lookahead adder/subtractor. The operation is cut
//   into STAGES slices of SW = WIDTH/STAGES bits; stage k adds slice k using
//   the carry registered by stage k-1. Operands travel with the op so later
//   slices are naturally skewed, and finished slices are carried along so the
//   result leaves fully aligned after STAGES cycles. One op per cycle, with a
//   single global advance enable driven by the output handshake.
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid / in_ready  input handshake
//   in_a, in_b           operands (WIDTH)
//   in_cin               carry-in, add only
//   in_sub               0: A+B+cin, 1: A-B
//   out_valid/out_ready  output handshake
//   out_sum              result mod 2^WIDTH
//   out_cout             carry out of MSB (subtract: 1 = no borrow)
//   out_ovf              signed overflow
//   out_zero             out_sum == 0
// ---------------------------------------------------------------------------
module cla_addsub_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int SW = WIDTH / STAGES;

    if (STAGES < 1 || (WIDTH % (GRP_W * STAGES)) != 0) begin : g_bad_param
        $error("cla_addsub_pipe: WIDTH (%0d) must be a multiple of %0d*STAGES (STAGES=%0d)",
               WIDTH, GRP_W, STAGES);
    end

    op_e              op;
    logic             en;
    logic [WIDTH-1:0] b_eff;
    logic             cin0;

    // Stage k registers: everything the op needs after slice k is done.
    logic             vld_p  [STAGES];
    logic [WIDTH-1:0] a_p    [STAGES];
    logic [WIDTH-1:0] b_p    [STAGES];
    logic [WIDTH-1:0] sum_p  [STAGES];
    logic             c_p    [STAGES];
    logic             zero_p [STAGES];
    logic             ovf_p  [STAGES];

    assign op    = op_e'(in_sub);
    assign b_eff = (op == OP_SUB) ? ~in_b : in_b;
    assign cin0  = carry_in0(op, in_cin);

    // The whole pipe moves together: it may advance whenever the head slot is
    // empty or is being taken this cycle.
    assign en       = !vld_p[STAGES-1] || out_ready;
    assign in_ready = en;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             v_i;
        logic [WIDTH-1:0] a_i;
        logic [WIDTH-1:0] b_i;
        logic [WIDTH-1:0] s_i;
        logic             c_i;
        logic             z_i;
        logic [SW-1:0]    sl_sum;
        logic             sl_cout;
        logic             sl_cmsb;
        logic             sl_zero;
        logic [WIDTH-1:0] s_n;

        if (k == 0) begin : g_head
            assign v_i = in_valid;
            assign a_i = in_a;
            assign b_i = b_eff;
            assign s_i = '0;
            assign c_i = cin0;
            assign z_i = 1'b1;
        end else begin : g_body
            assign v_i = vld_p[k-1];
            assign a_i = a_p[k-1];
            assign b_i = b_p[k-1];
            assign s_i = sum_p[k-1];
            assign c_i = c_p[k-1];
            assign z_i = zero_p[k-1];
        end

        cla_slice #(
            .SW (SW)
        ) u_slice (
            .a     (a_i[k*SW +: SW]),
            .b     (b_i[k*SW +: SW]),
            .cin   (c_i),
            .sum   (sl_sum),
            .cout  (sl_cout),
            .c_msb (sl_cmsb),
            .zero  (sl_zero)
        );

        // Drop this slice's result into its place among the finished slices.
        always_comb begin
            s_n = s_i;
            s_n[k*SW +: SW] = sl_sum;
        end

        // ---- stage k register boundary ----
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                vld_p[k]  <= 1'b0;
                a_p[k]    <= '0;
                b_p[k]    <= '0;
                sum_p[k]  <= '0;
                c_p[k]    <= 1'b0;
                zero_p[k] <= 1'b0;
                ovf_p[k]  <= 1'b0;
            end else if (en) begin
                vld_p[k]  <= v_i;
                a_p[k]    <= a_i;
                b_p[k]    <= b_i;
                sum_p[k]  <= s_n;
                c_p[k]    <= sl_cout;
                zero_p[k] <= z_i & sl_zero;
                // Only meaningful in the last stage, where the slice MSB is
                // the word MSB.
                ovf_p[k]  <= sl_cmsb ^ sl_cout;
            end
        end
    end

    assign out_valid = vld_p[STAGES-1];
    assign out_sum   = sum_p[STAGES-1];
    assign out_cout  = c_p[STAGES-1];
    assign out_ovf   = ovf_p[STAGES-1];
    assign out_zero  = zero_p[STAGES-1];

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// ---------------------------------------------------------------------------
// tb_cla_addsub_pipe
//   Self-checking bench for cla_addsub_pipe (WIDTH=32, STAGES=2): directed
//   arithmetic corners, latency, backpressure, mid-flight reset and a long
//   randomized run against an integer-arithmetic reference.
// ---------------------------------------------------------------------------
module tb_cla_addsub_pipe;

    localparam int W = 32;
    localparam int S = 2;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;
    logic         out_zero;

    int checks = 0;
    int errors = 0;

    cla_addsub_pipe #(
        .WIDTH  (W),
        .STAGES (S)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: plain integer arithmetic. Returns {cout, ovf, zero, sum}.
    function automatic logic [W+2:0] golden(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic cin, input logic sub);
        longint ua, ub, sa, sb, ur, sr;
        logic [W-1:0] s;
        logic co, ov;
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sub) begin
            ur = ua - ub;
            sr = sa - sb;
            co = (ur >= 64'sd0);
        end else begin
            ur = ua + ub + longint'(cin);
            sr = sa + sb + longint'(cin);
            co = (ur > 64'sd4294967295);
        end
        s  = ur[W-1:0];
        ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        return {co, ov, (s == '0), s};
    endfunction

    // Drives one op into an idle pipe with out_ready=1 and waits for it.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic sub, output logic [W+2:0] res, output int lat,
                          output bit got);
        @(negedge clk);
        in_a = a; in_b = b; in_cin = cin; in_sub = sub;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 16) begin
            @(negedge clk);
            lat++;
        end
        got = out_valid;
        res = {out_cout, out_ovf, out_zero, out_sum};
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_sum !== '0) begin errors++; $display("FAIL reset_out_sum got %h want 0", out_sum); end
        checks++; if ({out_cout, out_ovf, out_zero} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {out_cout, out_ovf, out_zero}); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_add_wrap();
        logic [W+2:0] r; int lat; bit got;
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, r, lat, got);
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL add_wrap_timeout got %b want 1", got); end
        checks++; if (lat != S) begin errors++; $display("FAIL add_wrap_latency got %0d want %0d", lat, S); end
        checks++; if (r !== {1'b1, 1'b0, 1'b1, 32'h0000_0000}) begin errors++; $display("FAIL add_wrap got %h want %h", r, {1'b1, 1'b0, 1'b1, 32'h0}); end
    endtask

    task automatic test_sub();
        logic [W+2:0] r; int lat; bit got;
        run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, r, lat, got);
        checks++; if (!got || r !== {1'b1, 1'b1, 1'b0, 32'h7FFF_FFFF}) begin errors++; $display("FAIL sub_min_minus_1 got %h want %h", r, {1'b1, 1'b1, 1'b0, 32'h7FFF_FFFF}); end
        // cin must be ignored for subtract
        run_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, r, lat, got);
        checks++; if (!got || r !== {1'b0, 1'b0, 1'b0, 32'hFFFF_FFFE}) begin errors++; $display("FAIL sub_5_7 got %h want %h", r, {1'b0, 1'b0, 1'b0, 32'hFFFF_FFFE}); end
        run_op(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, r, lat, got);
        checks++; if (!got || r !== {1'b1, 1'b0, 1'b1, 32'h0}) begin errors++; $display("FAIL sub_equal got %h want %h", r, {1'b1, 1'b0, 1'b1, 32'h0}); end
    endtask

    task automatic test_slice_carry();
        logic [W+2:0] r; int lat; bit got;
        run_op(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, r, lat, got);
        checks++; if (!got || r !== {1'b0, 1'b0, 1'b0, 32'h0001_0000}) begin errors++; $display("FAIL slice_carry got %h want %h", r, {1'b0, 1'b0, 1'b0, 32'h0001_0000}); end
        run_op(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, r, lat, got);
        checks++; if (!got || r !== {1'b0, 1'b1, 1'b0, 32'h8000_0000}) begin errors++; $display("FAIL cin_ovf got %h want %h", r, {1'b0, 1'b1, 1'b0, 32'h8000_0000}); end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] oa [3];
        logic [W-1:0] ob [3];
        logic         oc [3];
        logic         os [3];
        logic [W+2:0] ex [3];
        int sent, rx, prev;
        oa[0] = 32'h0000_0001; ob[0] = 32'h0000_0002; oc[0] = 1'b0; os[0] = 1'b0;
        oa[1] = 32'hFFFF_FFFF; ob[1] = 32'hFFFF_FFFF; oc[1] = 1'b1; os[1] = 1'b0;
        oa[2] = 32'h0000_000A; ob[2] = 32'h0000_0003; oc[2] = 1'b0; os[2] = 1'b1;
        for (int i = 0; i < 3; i++) ex[i] = golden(oa[i], ob[i], oc[i], os[i]);
        sent = 0;
        for (int c = 0; c < 6 && sent < 3; c++) begin
            @(negedge clk);
            out_ready = 1'b0;
            in_valid = 1'b1;
            in_a = oa[sent]; in_b = ob[sent]; in_cin = oc[sent]; in_sub = os[sent];
            #1;
            if (!in_ready) break;
            @(posedge clk);
            sent++;
        end
        checks++; if (sent != 2) begin errors++; $display("FAIL bp_accepted_before_stall got %0d want 2", sent); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_head_valid got %b want 1", out_valid); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_stall got %b want 0", in_ready); end
            checks++; if ({out_cout, out_ovf, out_zero, out_sum} !== ex[0] || out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold got %h want %h", {out_cout, out_ovf, out_zero, out_sum}, ex[0]); end
        end
        rx = 0; prev = -1;
        for (int c = 0; c < 10 && rx < 3; c++) begin
            if (c > 0) @(negedge clk);
            if (sent == 3) in_valid = 1'b0;
            out_ready = 1'b1;
            #1;
            if (out_valid) begin
                checks++; if ({out_cout, out_ovf, out_zero, out_sum} !== ex[rx]) begin errors++; $display("FAIL bp_result%0d got %h want %h", rx, {out_cout, out_ovf, out_zero, out_sum}, ex[rx]); end
                if (rx > 0) begin
                    checks++; if (c != prev + 1) begin errors++; $display("FAIL bp_gap got %0d want %0d", c - prev, 1); end
                end
                prev = c;
                rx++;
            end
            if (in_valid && in_ready) sent++;
        end
        checks++; if (rx != 3 || sent != 3) begin errors++; $display("FAIL bp_drain got rx=%0d sent=%0d want 3/3", rx, sent); end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset_midflight();
        logic [W+2:0] r; int lat; bit got; int ghosts;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            out_ready = 1'b0;
            in_valid = 1'b1;
            in_a = 32'h1111_0000 + i; in_b = 32'h0000_0101; in_cin = 1'b0; in_sub = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_inflight got %b want 1", out_valid); end
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checks++; if (out_valid !== 1'b0 || out_sum !== '0) begin errors++; $display("FAIL rst_mid_flush got valid=%b sum=%h want 0/0", out_valid, out_sum); end
        out_ready = 1'b1;
        ghosts = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid) ghosts++;
        end
        checks++; if (ghosts != 0) begin errors++; $display("FAIL rst_mid_ghost got %0d want 0", ghosts); end
        run_op(32'hDEAD_BEEF, 32'h0123_4567, 1'b1, 1'b0, r, lat, got);
        checks++; if (!got || r !== golden(32'hDEAD_BEEF, 32'h0123_4567, 1'b1, 1'b0)) begin errors++; $display("FAIL rst_mid_after got %h want %h", r, golden(32'hDEAD_BEEF, 32'h0123_4567, 1'b1, 1'b0)); end
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'h0000_FFFF;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic test_random(input int nops);
        logic [W+2:0] q [$];
        logic [W+2:0] e, got, held;
        logic [W-1:0] a, b;
        logic cin, sub, stalled;
        int sent, rcvd, cyc;
        sent = 0; rcvd = 0; cyc = 0; stalled = 1'b0; held = '0;
        while ((sent < nops || q.size() > 0) && cyc < nops * 8 + 100) begin
            @(negedge clk);
            cyc++;
            if (stalled) begin
                checks++; if ({out_cout, out_ovf, out_zero, out_sum} !== held || out_valid !== 1'b1) begin errors++; $display("FAIL rand_hold got %h want %h", {out_cout, out_ovf, out_zero, out_sum}, held); end
            end
            a = pick_operand(); b = pick_operand();
            cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            in_valid = (sent < nops) && ($urandom_range(0, 3) != 0);
            in_a = a; in_b = b; in_cin = cin; in_sub = sub;
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            checks++; if (in_ready !== (!out_valid || out_ready)) begin errors++; $display("FAIL rand_in_ready got %b want %b", in_ready, (!out_valid || out_ready)); end
            if (out_valid && out_ready) begin
                got = {out_cout, out_ovf, out_zero, out_sum};
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL rand_extra got %h want none", got);
                end else begin
                    e = q.pop_front();
                    if (got !== e) begin errors++; $display("FAIL rand_result%0d got %h want %h", rcvd, got, e); end
                    rcvd++;
                end
            end
            stalled = out_valid && !out_ready;
            held = {out_cout, out_ovf, out_zero, out_sum};
            if (in_valid && in_ready) begin
                q.push_back(golden(a, b, cin, sub));
                sent++;
            end
        end
        checks++; if (sent != nops || rcvd != nops || q.size() != 0) begin errors++; $display("FAIL rand_count got sent=%0d rcvd=%0d pending=%0d want %0d", sent, rcvd, q.size(), nops); end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_add_wrap();
        test_sub();
        test_slice_carry();
        test_backpressure();
        test_reset_midflight();
        test_random(3000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
